// File: rtl/ppg_frontend_ctrl_pkg.sv
// Shared types and statistics helpers for the PPG optical front-end controller.
package ppg_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DC_SEARCH,
    ST_PGA_PROBE,
    ST_PGA_UP,
    ST_PGA_DOWN,
    ST_NEXT_CH,
    ST_RUN,
    ST_FAIL
  } state_e;

  // Widened arithmetic so max+min never overflows the ADC width.
  function automatic int unsigned midpoint(input int unsigned max_v, input int unsigned min_v);
    return (max_v + min_v) >> 1;
  endfunction

  function automatic logic clipped(input int unsigned min_v, max_v, lo, hi);
    return (min_v <= lo) || (max_v >= hi);
  endfunction

  function automatic logic is_cal_state(input state_e s);
    return (s == ST_DC_SEARCH) || (s == ST_PGA_PROBE) || (s == ST_PGA_UP) ||
           (s == ST_PGA_DOWN) || (s == ST_NEXT_CH);
  endfunction

endpackage

// File: rtl/ppg_frontend_ctrl_stats.sv
// Free-running settle/window counter with min/max tracking; done_o marks the
// evaluate cycle, after which a new window starts automatically.
module adc_window_stats
  import ppg_ctrl_pkg::*;
#(
  parameter int unsigned ADC_W  = 8,
  parameter int unsigned WIN    = 1000,
  parameter int unsigned SETTLE = 4
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic [ADC_W-1:0] adc_i,
  output logic [ADC_W-1:0] min_o,
  output logic [ADC_W-1:0] max_o,
  output logic             done_o
);

  localparam int unsigned LAST  = SETTLE + WIN;
  localparam int unsigned CNT_W = $clog2(LAST + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ADC_W-1:0] min_q, min_d, max_q, max_d;

  always_comb begin
    cnt_d  = cnt_q;
    min_d  = min_q;
    max_d  = max_q;
    done_o = (32'(cnt_q) == LAST);
    if (clear_i || done_o) begin
      cnt_d = '0;
      min_d = '1;
      max_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      if (32'(cnt_q) >= SETTLE) begin
        if (adc_i < min_q) min_d = adc_i;
        if (adc_i > max_q) max_d = adc_i;
      end
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      min_q <= '1;
      max_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign min_o = min_q;
  assign max_o = max_q;

endmodule

// File: rtl/ppg_frontend_ctrl.sv
// N-channel PPG front-end controller: per-channel DC-comp/PGA calibration from
// windowed ADC statistics, then round-robin LED slots capturing one sample each.
module ppg_frontend_ctrl
  import ppg_ctrl_pkg::*;
#(
  parameter int unsigned N_CH        = 2,
  parameter int unsigned ADC_W       = 8,
  parameter int unsigned DC_W        = 7,
  parameter int unsigned PGA_W       = 4,
  parameter int unsigned WIN         = 1000,
  parameter int unsigned SETTLE      = 4,
  parameter int unsigned DC_LO       = 120,
  parameter int unsigned DC_HI       = 135,
  parameter int unsigned CLIP_LO     = 10,
  parameter int unsigned CLIP_HI     = 245,
  parameter int unsigned DC_INIT     = 100,
  parameter int unsigned PGA_INIT    = 7,
  parameter int unsigned DC_DN       = 5,
  parameter int unsigned DC_UP       = 1,
  parameter int unsigned DC_MAX_ITER = 64,
  parameter int unsigned SLOT_CYC    = 10
) (
  input  logic                   CLK,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [ADC_W-1:0]       adc_i,
  output logic [N_CH-1:0]        led_en_o,
  output logic [DC_W-1:0]        dc_comp_o,
  output logic [PGA_W-1:0]       pga_gain_o,
  output logic                   clk_filter_o,
  output logic                   busy_o,
  output logic                   cal_done_o,
  output logic                   cal_fail_o,
  output logic [N_CH-1:0]        clip_warn_o,
  output logic [N_CH*ADC_W-1:0]  sample_data_o,
  output logic [N_CH-1:0]        sample_valid_o
);

  localparam int unsigned CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned IT_W     = $clog2(DC_MAX_ITER + 1);
  localparam int unsigned SL_W     = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam int unsigned DC_MAX_V = (1 << DC_W) - 1;
  localparam logic [N_CH-1:0]  LED_ONE    = N_CH'(1);
  localparam logic [DC_W-1:0]  DC_INIT_C  = DC_W'(DC_INIT);
  localparam logic [PGA_W-1:0] PGA_INIT_C = PGA_W'(PGA_INIT);

  state_e                 state_q, state_d;
  logic [CH_W-1:0]        ch_q, ch_d, ch_nxt, ch_run;
  logic [DC_W-1:0]        dc_q, dc_d;
  logic [PGA_W-1:0]       pga_q, pga_d;
  logic [N_CH-1:0]        led_q, led_d;
  logic [IT_W-1:0]        iter_q, iter_d;
  logic [SL_W-1:0]        slot_q, slot_d;
  logic [DC_W-1:0]        dc_st_q  [N_CH];
  logic [DC_W-1:0]        dc_st_d  [N_CH];
  logic [PGA_W-1:0]       pga_st_q [N_CH];
  logic [PGA_W-1:0]       pga_st_d [N_CH];
  logic [N_CH-1:0]        clip_warn_q, clip_warn_d;
  logic                   cal_fail_q, cal_fail_d;
  logic                   busy_q, busy_d;
  logic                   cal_done_q, cal_done_d;
  logic                   clk_filter_q;
  logic [N_CH*ADC_W-1:0]  sample_data_q, sample_data_d;
  logic [N_CH-1:0]        sample_valid_q, sample_valid_d;

  logic                   win_clear, win_done, clip, in_band;
  logic [ADC_W-1:0]       win_min, win_max;
  int unsigned            avg;

  adc_window_stats #(
    .ADC_W  (ADC_W),
    .WIN    (WIN),
    .SETTLE (SETTLE)
  ) u_stats (
    .CLK     (CLK),
    .rst_n   (rst_n),
    .clear_i (win_clear),
    .adc_i   (adc_i),
    .min_o   (win_min),
    .max_o   (win_max),
    .done_o  (win_done)
  );

  assign avg     = midpoint(32'(win_max), 32'(win_min));
  assign clip    = clipped(32'(win_min), 32'(win_max), CLIP_LO, CLIP_HI);
  assign in_band = (avg >= DC_LO) && (avg <= DC_HI);
  assign ch_nxt  = ch_q + CH_W'(1);
  assign ch_run  = (32'(ch_q) == N_CH - 1) ? '0 : ch_nxt;

  always_comb begin
    state_d        = state_q;
    ch_d           = ch_q;
    dc_d           = dc_q;
    pga_d          = pga_q;
    led_d          = led_q;
    iter_d         = iter_q;
    slot_d         = slot_q;
    dc_st_d        = dc_st_q;
    pga_st_d       = pga_st_q;
    clip_warn_d    = clip_warn_q;
    cal_fail_d     = cal_fail_q;
    sample_data_d  = sample_data_q;
    sample_valid_d = '0;
    win_clear      = 1'b0;

    if (abort_i) begin
      state_d = ST_IDLE;
      led_d   = '0;
    end else if (start_i) begin
      state_d     = ST_DC_SEARCH;
      ch_d        = '0;
      dc_d        = DC_INIT_C;
      pga_d       = '0;
      led_d       = LED_ONE;
      iter_d      = '0;
      dc_st_d     = '{default: '0};
      pga_st_d    = '{default: '0};
      clip_warn_d = '0;
      cal_fail_d  = 1'b0;
      win_clear   = 1'b1;
    end else begin
      unique case (state_q)
        ST_DC_SEARCH: if (win_done) begin
          if (in_band) begin
            dc_st_d[ch_q] = dc_q;
            pga_d         = PGA_INIT_C;
            state_d       = ST_PGA_PROBE;
          end else if (32'(iter_q) + 1 >= DC_MAX_ITER) begin
            state_d    = ST_FAIL;
            led_d      = '0;
            cal_fail_d = 1'b1;
          end else begin
            iter_d = iter_q + IT_W'(1);
            if (avg < DC_LO)
              dc_d = (32'(dc_q) < DC_DN) ? '0 : dc_q - DC_W'(DC_DN);
            else
              dc_d = (32'(dc_q) + DC_UP > DC_MAX_V) ? '1 : dc_q + DC_W'(DC_UP);
          end
        end
        ST_PGA_PROBE: if (win_done) begin
          if (clip) begin
            pga_d   = (pga_q == '0) ? '0 : pga_q - PGA_W'(1);
            state_d = ST_PGA_DOWN;
          end else begin
            pga_d   = (pga_q == '1) ? '1 : pga_q + PGA_W'(1);
            state_d = ST_PGA_UP;
          end
        end
        ST_PGA_UP: if (win_done) begin
          if (!clip && pga_q != '1) begin
            pga_d = pga_q + PGA_W'(1);
          end else begin
            // Clipping here means the previous (one lower) gain was the last clean one.
            pga_st_d[ch_q] = !clip ? pga_q : ((pga_q == '0) ? '0 : pga_q - PGA_W'(1));
            state_d        = ST_NEXT_CH;
          end
        end
        ST_PGA_DOWN: if (win_done) begin
          if (clip && pga_q != '0) begin
            pga_d = pga_q - PGA_W'(1);
          end else begin
            pga_st_d[ch_q] = pga_q;
            if (clip) clip_warn_d[ch_q] = 1'b1;
            state_d = ST_NEXT_CH;
          end
        end
        ST_NEXT_CH: begin
          if (32'(ch_q) < N_CH - 1) begin
            ch_d      = ch_nxt;
            dc_d      = DC_INIT_C;
            pga_d     = '0;
            led_d     = LED_ONE << ch_nxt;
            iter_d    = '0;
            win_clear = 1'b1;
            state_d   = ST_DC_SEARCH;
          end else begin
            ch_d    = '0;
            led_d   = LED_ONE;
            dc_d    = dc_st_q[0];
            pga_d   = pga_st_q[0];
            slot_d  = '0;
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (32'(slot_q) == SLOT_CYC - 1) begin
            sample_data_d[ch_q*ADC_W +: ADC_W] = adc_i;
            sample_valid_d = LED_ONE << ch_q;
            ch_d   = ch_run;
            led_d  = LED_ONE << ch_run;
            dc_d   = dc_st_q[ch_run];
            pga_d  = pga_st_q[ch_run];
            slot_d = '0;
          end else begin
            slot_d = slot_q + SL_W'(1);
          end
        end
        default: ;
      endcase
    end

    busy_d     = is_cal_state(state_d);
    cal_done_d = (state_d == ST_RUN);
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      ch_q           <= '0;
      dc_q           <= DC_INIT_C;
      pga_q          <= '0;
      led_q          <= '0;
      iter_q         <= '0;
      slot_q         <= '0;
      dc_st_q        <= '{default: '0};
      pga_st_q       <= '{default: '0};
      clip_warn_q    <= '0;
      cal_fail_q     <= 1'b0;
      busy_q         <= 1'b0;
      cal_done_q     <= 1'b0;
      clk_filter_q   <= 1'b0;
      sample_data_q  <= '0;
      sample_valid_q <= '0;
    end else begin
      state_q        <= state_d;
      ch_q           <= ch_d;
      dc_q           <= dc_d;
      pga_q          <= pga_d;
      led_q          <= led_d;
      iter_q         <= iter_d;
      slot_q         <= slot_d;
      dc_st_q        <= dc_st_d;
      pga_st_q       <= pga_st_d;
      clip_warn_q    <= clip_warn_d;
      cal_fail_q     <= cal_fail_d;
      busy_q         <= busy_d;
      cal_done_q     <= cal_done_d;
      clk_filter_q   <= ~clk_filter_q;
      sample_data_q  <= sample_data_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  assign led_en_o       = led_q;
  assign dc_comp_o      = dc_q;
  assign pga_gain_o     = pga_q;
  assign clk_filter_o   = clk_filter_q;
  assign busy_o         = busy_q;
  assign cal_done_o     = cal_done_q;
  assign cal_fail_o     = cal_fail_q;
  assign clip_warn_o    = clip_warn_q;
  assign sample_data_o  = sample_data_q;
  assign sample_valid_o = sample_valid_q;

endmodule
